// File: rtl/gsim_mat_mem_resp_pkg.sv
// Shared types and constants for the GSIM matrix-memory responder.
// The state encodings and matrix geometry are common to the GSIM core and this block.
package gsim_mat_mem_resp_pkg;

    typedef enum logic [1:0] {
        MR_SLEEP  = 2'd0,
        MR_WAKE   = 2'd1,
        MR_ACTIVE = 2'd2
    } mr_state_e;

    localparam int MAT_WORDS = 17;
    localparam int MAT_DEPTH = 544;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 256;
    localparam int OUT_CNT_W = 4;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
        return int'({22'd0, addr}) < depth;
    endfunction

endpackage

// File: rtl/gsim_lat_pipe.sv
// Shift register of {valid, err} tracking each accepted read until its response cycle.
// Exposes the stage before the output so the data register can load in step with it.
module gsim_lat_pipe #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_vld,
    input  logic i_err,
    output logic o_pre_vld,
    output logic o_vld,
    output logic o_err
);

    logic [STAGES-1:0] vld_reg;
    logic [STAGES-1:0] vld_next;
    logic [STAGES-1:0] err_reg;
    logic [STAGES-1:0] err_next;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign vld_next[gi] = i_vld;
                assign err_next[gi] = i_err;
            end else begin : g_tail
                assign vld_next[gi] = vld_reg[gi-1];
                assign err_next[gi] = err_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_reg <= '0;
            err_reg <= '0;
        end else begin
            vld_reg <= vld_next;
            err_reg <= err_next;
        end
    end

    assign o_pre_vld = vld_reg[STAGES-2];
    assign o_vld     = vld_reg[STAGES-1];
    assign o_err     = err_reg[STAGES-1];

endmodule

// File: rtl/gsim_mat_mem_resp.sv
// GSIM matrix-memory read responder: accepts requests, drives the matrix SRAM,
// returns data in order, limits outstanding reads and sleeps the SRAM when idle.
module gsim_mat_mem_resp
    import gsim_mat_mem_resp_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int MAX_OUT  = 4,
    parameter int DEPTH    = MAT_DEPTH,
    parameter int IDLE_TO  = 16,
    parameter int WAKE_CYC = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_mem_rreq,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic              o_mem_rrdy,
    output logic [DATA_W-1:0] o_mem_dout,
    output logic              o_mem_dout_vld,
    output logic              o_sram_ren,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_slp,
    input  logic [DATA_W-1:0] i_sram_q,
    input  logic              i_sram_busy,
    output logic              o_err
);

    localparam int STAGES = READ_LAT + 1;
    localparam int IDLE_W = (IDLE_TO < 1) ? 1 : $clog2(IDLE_TO + 1);
    localparam int WAKE_W = (WAKE_CYC < 1) ? 1 : $clog2(WAKE_CYC + 1);

    mr_state_e            state_reg;
    mr_state_e            state_next;
    logic [WAKE_W-1:0]    wake_cnt_reg;
    logic [WAKE_W-1:0]    wake_cnt_next;
    logic [IDLE_W-1:0]    idle_cnt_reg;
    logic [IDLE_W-1:0]    idle_cnt_next;
    logic [OUT_CNT_W-1:0] out_cnt_reg;
    logic [OUT_CNT_W-1:0] out_cnt_next;
    logic [DATA_W-1:0]    dout_reg;
    logic                 err_reg;

    logic accept;
    logic in_range;
    logic pre_vld;
    logic out_vld;
    logic out_err;

    // A response retiring this cycle frees its slot, so the limit still allows
    // one accept per cycle when MAX_OUT covers the full round trip.
    assign o_mem_rrdy = (state_reg == MR_ACTIVE) && !i_sram_busy &&
                        ((out_cnt_reg < OUT_CNT_W'(MAX_OUT)) || out_vld);

    assign accept      = i_mem_rreq && o_mem_rrdy;
    assign in_range    = addr_in_range(i_mem_addr, DEPTH);
    assign o_sram_ren  = accept && in_range;
    assign o_sram_addr = i_mem_addr;
    assign o_sram_slp  = (state_reg == MR_SLEEP);

    gsim_lat_pipe #(
        .STAGES(STAGES)
    ) u_lat_pipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_vld     (accept),
        .i_err     (accept && !in_range),
        .o_pre_vld (pre_vld),
        .o_vld     (out_vld),
        .o_err     (out_err)
    );

    assign o_mem_dout_vld = out_vld;
    assign o_mem_dout     = out_err ? '0 : dout_reg;
    assign o_err          = err_reg;

    always_comb begin
        out_cnt_next = out_cnt_reg;
        if (accept && !out_vld) begin
            out_cnt_next = out_cnt_reg + 1'b1;
        end else if (!accept && out_vld && (out_cnt_reg != '0)) begin
            out_cnt_next = out_cnt_reg - 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wake_cnt_next = wake_cnt_reg;
        idle_cnt_next = idle_cnt_reg;
        case (state_reg)
            MR_SLEEP: begin
                idle_cnt_next = '0;
                if (i_mem_rreq) begin
                    state_next    = MR_WAKE;
                    wake_cnt_next = WAKE_W'(WAKE_CYC);
                end
            end
            MR_WAKE: begin
                if (wake_cnt_reg != '0) begin
                    wake_cnt_next = wake_cnt_reg - 1'b1;
                end
                if (wake_cnt_reg <= WAKE_W'(1)) begin
                    state_next = MR_ACTIVE;
                end
            end
            MR_ACTIVE: begin
                // An accept in the timeout cycle keeps the SRAM awake.
                if (accept || (out_cnt_reg != '0)) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg == IDLE_W'(IDLE_TO)) begin
                    state_next    = MR_SLEEP;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = MR_SLEEP;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg    <= MR_SLEEP;
            wake_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            out_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wake_cnt_reg <= wake_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
            out_cnt_reg  <= out_cnt_next;
        end
    end

    // Data register loads only in the cycle the SRAM word belongs to a live request.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dout_reg <= '0;
        end else if (pre_vld) begin
            dout_reg <= i_sram_q;
        end else begin
            dout_reg <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_reg <= 1'b0;
        end else if (accept && !in_range) begin
            err_reg <= 1'b1;
        end
    end

endmodule
